control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multicycle control unit that sequences the shared RV32I datapath (single ALU, unified instruction/data memory, PC, IR, ALUOut and Data registers) for the multicycle processor variant. It decodes the latched instruction fields and steps a Moore FSM through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, and handshakes with a variable-latency memory. It also counts retired instructions and halts on unsupported encodings.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `op_i`  in  7  opcode field of the IR (Instr[6:0]).
- `funct3_i`  in  3  Instr[14:12].
- `funct7b5_i`  in  1  Instr[30].
- `zero_i`  in  1  ALU zero flag.
- `mem_ready_i`  in  1  memory completes the current access this cycle.
- `mem_req_o`  out  1  memory access request.
- `mem_write_o`  out  1  request is a store.
- `adr_src_o`  out  1  memory address select: 0 = PC, 1 = Result.
- `ir_write_o`  out  1  load IR and OldPC.
- `pc_write_o`  out  1  load PC from Result.
- `reg_write_o`  out  1  register-file write enable.
- `result_src_o`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a_o`  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b_o`  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- `alu_control_o`  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `imm_src_o`  out  2  00 = I, 01 = S, 10 = B, 11 = J; decoded combinationally from `op_i`.
- `state_o`  out  4  current state encoding, for debug.
- `halted_o`  out  1  FSM is in HALT.
- `instret_o`  out  CNT_W  retired-instruction count.

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, HALT = 11
- FETCH:
  - Drives mem_req = 1, adr_src = 0, srcA = 00, srcB = 10, add, result_src = 10.
  - `ir_write_o` and `pc_write_o` are asserted only while `mem_ready_i` = 1.
  - On ready, go to DECODE; otherwise stay in FETCH.
- DECODE: drives srcA = 01, srcB = 01, add (computes the branch/jump target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → HALT
  - funct3 outside {000, 010, 110, 111} for R/I instructions, or funct3 ≠ 000 for beq → HALT
- MEMADR: drives srcA = 10, srcB = 01, add. Next state is MEMREAD if op[5] = 0, MEMWRITE if op[5] = 1.
- MEMREAD:
  - Drives mem_req = 1, adr_src = 1, result_src = 00.
  - Stays until ready, then goes to MEMWB.
- MEMWB: drives result_src = 01, reg_write = 1, then goes to FETCH.
- MEMWRITE:
  - Drives mem_req = 1, mem_write = 1, adr_src = 1, result_src = 00.
  - Stays until ready, then goes to FETCH.
- EXECR / EXECI:
  - Drive srcA = 10; srcB = 00 (EXECR) or 01 (EXECI); ALU function from funct3/funct7.
  - Next state is ALUWB.
- ALU function decode:
  - funct3 000: sub when op[5] & funct7b5, otherwise add.
  - funct3 010 → slt, 110 → or, 111 → and.
- ALUWB: drives result_src = 00, reg_write = 1, then goes to FETCH.
- BEQ:
  - Drives srcA = 10, srcB = 00, sub, result_src = 00.
  - `pc_write_o` = `zero_i` (combinational).
  - Next state is FETCH.
- JAL: drives srcA = 01, srcB = 10, add, result_src = 00, pc_write = 1. Next state is ALUWB.
- HALT: all enables and the request are 0, `halted_o` = 1; the state is kept until reset.
- `instret_o` increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0.

## Timing
- Reset (async assert):
  - State = FETCH, `instret_o` = 0, `halted_o` = 0.
  - Outputs immediately take their FETCH values (mem_req = 1, no write strobes, because ready is gated).
  - Reset during MEMREAD/MEMWRITE abandons the access with no write-back.
- Cycles per instruction with `mem_ready_i` held at 1:
  - lw 5
  - sw, R-type, I-type, jal 4
  - beq 3
- Each cycle `mem_ready_i` is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_ready_i` is ignored outside request states.
- `mem_req_o` and the address select are stable from the first request cycle until the ready cycle inclusive.

## Test plan
- Reset then lw (op 0000011), ready = 1 → state sequence 0, 1, 2, 3, 4, 0; reg_write only in MEMWB; instret = 1 after 5 cycles.
- add then sub (op 0110011, funct3 000, funct7b5 0/1) → alu_control 000 then 001 in EXECR; 4 cycles each; instret = 2.
- beq with zero_i = 1 and then 0 → pc_write = 1 in the first BEQ cycle, 0 in the second; 3 cycles each.
- FETCH with ready low for 3 cycles → mem_req held, ir_write/pc_write = 0 for 3 cycles, both 1 on cycle 4; sw stalled 2 cycles in MEMWRITE → 8 cycles total.
- Opcode 1111111 → HALT after DECODE, halted_o = 1, all enables 0 for 20 cycles; rst_ni low → state 0, halted 0.
- CNT_W = 4, 17 I-type instructions → instret wraps to 1; reset asserted mid-MEMREAD → reg_write never pulses and instret = 0.

Source files
------------

// File: rtl/control_multiciclo.sv
// Moore control unit for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and write-back, handshakes with a variable-latency memory.
module control_multiciclo #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_control_o,
    output logic [1:0]       imm_src_o,
    output logic [3:0]       state_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t           state_q;
    state_t           state_d;
    state_t           decode_next;
    logic [CNT_W-1:0] instret_q;
    logic [2:0]       alu_fn;
    logic             f3_alu_ok;
    logic             retire;

    assign f3_alu_ok = (funct3_i == 3'b000) || (funct3_i == 3'b010) ||
                       (funct3_i == 3'b110) || (funct3_i == 3'b111);

    // Only I-type shares funct3 000 with R-type; op[5] keeps addi from becoming sub.
    always_comb begin
        case (funct3_i)
            3'b000:  alu_fn = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
            3'b010:  alu_fn = 3'b101;
            3'b110:  alu_fn = 3'b011;
            3'b111:  alu_fn = 3'b010;
            default: alu_fn = 3'b000;
        endcase
    end

    always_comb begin
        case (op_i)
            OP_LOAD, OP_STORE: decode_next = MEMADR;
            OP_RTYPE:          decode_next = f3_alu_ok ? EXECR : HALT;
            OP_ITYPE:          decode_next = f3_alu_ok ? EXECI : HALT;
            OP_BRANCH:         decode_next = (funct3_i == 3'b000) ? BEQ : HALT;
            OP_JAL:            decode_next = JAL;
            default:           decode_next = HALT;
        endcase
    end

    always_comb begin
        case (op_i)
            OP_STORE:  imm_src_o = 2'b01;
            OP_BRANCH: imm_src_o = 2'b10;
            OP_JAL:    imm_src_o = 2'b11;
            default:   imm_src_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_o     = 1'b0;
        mem_write_o   = 1'b0;
        adr_src_o     = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        reg_write_o   = 1'b0;
        result_src_o  = 2'b00;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = 2'b00;
        alu_control_o = 3'b000;
        case (state_q)
            FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
                if (mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                state_d     = decode_next;
            end
            MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = op_i[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = MEMWB;
            end
            MEMWB: begin
                result_src_o = 2'b01;
                reg_write_o  = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                adr_src_o   = 1'b1;
                if (mem_ready_i) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a_o   = 2'b10;
                alu_control_o = alu_fn;
                state_d       = ALUWB;
            end
            EXECI: begin
                alu_src_a_o   = 2'b10;
                alu_src_b_o   = 2'b01;
                alu_control_o = alu_fn;
                state_d       = ALUWB;
            end
            ALUWB: begin
                reg_write_o = 1'b1;
                state_d     = FETCH;
            end
            BEQ: begin
                alu_src_a_o   = 2'b10;
                alu_control_o = 3'b001;
                pc_write_o    = zero_i;
                state_d       = FETCH;
            end
            JAL: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write_o  = 1'b1;
                state_d     = ALUWB;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // An instruction retires on the edge that returns the FSM to FETCH.
    assign retire = (state_d == FETCH) &&
                    ((state_q == MEMWB) || (state_q == MEMWRITE) ||
                     (state_q == ALUWB) || (state_q == BEQ));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign state_o   = state_q;
    assign halted_o  = (state_q == HALT);
    assign instret_o = instret_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: per-instruction expected state script,
// per-state output table, and a per-cycle compare on a 32-bit and a 4-bit counter build.
module tb_control_multiciclo;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                           S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                           S_BEQ = 4'd9, S_JAL = 4'd10, S_HALT = 4'd11;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, zero, rdy;

    logic        a_req, a_mw, a_adr, a_irw, a_pcw, a_rw, a_halt;
    logic [1:0]  a_rs, a_sa, a_sb, a_imm;
    logic [2:0]  a_alu;
    logic [3:0]  a_state;
    logic [31:0] a_instret;
    logic        b_req, b_mw, b_adr, b_irw, b_pcw, b_rw, b_halt;
    logic [1:0]  b_rs, b_sa, b_sb, b_imm;
    logic [2:0]  b_alu;
    logic [3:0]  b_state;
    logic [3:0]  b_instret;
    logic [21:0] act_a, act_b;

    int   n_chk = 0, n_fail = 0;
    int   exp_count = 0;
    int   icyc = 0;
    int   rw_cnt = 0;
    bit   chk_en = 1'b0, rw_mon = 1'b0;
    logic [3:0] exp_state = S_FETCH;
    logic [2:0] alu_seen = 3'b000;
    logic       pcw_seen = 1'b0;

    control_multiciclo #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
        .zero_i(zero), .mem_ready_i(rdy), .mem_req_o(a_req), .mem_write_o(a_mw),
        .adr_src_o(a_adr), .ir_write_o(a_irw), .pc_write_o(a_pcw), .reg_write_o(a_rw),
        .result_src_o(a_rs), .alu_src_a_o(a_sa), .alu_src_b_o(a_sb),
        .alu_control_o(a_alu), .imm_src_o(a_imm), .state_o(a_state),
        .halted_o(a_halt), .instret_o(a_instret));

    control_multiciclo #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
        .zero_i(zero), .mem_ready_i(rdy), .mem_req_o(b_req), .mem_write_o(b_mw),
        .adr_src_o(b_adr), .ir_write_o(b_irw), .pc_write_o(b_pcw), .reg_write_o(b_rw),
        .result_src_o(b_rs), .alu_src_a_o(b_sa), .alu_src_b_o(b_sb),
        .alu_control_o(b_alu), .imm_src_o(b_imm), .state_o(b_state),
        .halted_o(b_halt), .instret_o(b_instret));

    assign act_a = {a_req, a_mw, a_adr, a_irw, a_pcw, a_rw, a_rs, a_sa, a_sb, a_alu,
                    a_imm, a_state, a_halt};
    assign act_b = {b_req, b_mw, b_adr, b_irw, b_pcw, b_rw, b_rs, b_sa, b_sb, b_alu,
                    b_imm, b_state, b_halt};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected control word for a state, straight from the per-state output table.
    function automatic logic [21:0] exp_out(input logic [3:0] st, input logic [6:0] o,
                                            input logic [2:0] f, input logic f7b,
                                            input logic z, input logic r);
        logic req, mw, adr, irw, pcw, rw, hlt;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu, fn;
        {req, mw, adr, irw, pcw, rw, hlt} = 7'b0;
        {rs, sa, sb} = 6'b0;
        alu = 3'b000;
        imm = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        fn  = (f == 3'b000) ? {2'b00, o[5] & f7b} : (f == 3'b010) ? 3'b101 :
              (f == 3'b110) ? 3'b011 : (f == 3'b111) ? 3'b010 : 3'b000;
        case (st)
            S_FETCH:    begin req = 1; sb = 2'b10; rs = 2'b10; irw = r; pcw = r; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            S_MEMREAD:  begin req = 1; adr = 1; end
            S_MEMWB:    begin rs = 2'b01; rw = 1; end
            S_MEMWRITE: begin req = 1; mw = 1; adr = 1; end
            S_EXECR:    begin sa = 2'b10; alu = fn; end
            S_EXECI:    begin sa = 2'b10; sb = 2'b01; alu = fn; end
            S_ALUWB:    rw = 1;
            S_BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = z; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default:    hlt = 1;
        endcase
        return {req, mw, adr, irw, pcw, rw, rs, sa, sb, alu, imm, st, hlt};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    always @(negedge clk) begin
        if (chk_en && rst_ni) begin
            check("ctrl", 32'(act_a), 32'(exp_out(exp_state, op, f3, f7, zero, rdy)));
            check("ctrl_w4", 32'(act_b), 32'(exp_out(exp_state, op, f3, f7, zero, rdy)));
            check("instret", a_instret, 32'(exp_count));
            check("instret_w4", 32'(b_instret), 32'(exp_count & 15));
        end
        if (rw_mon && a_rw) rw_cnt++;
    end

    // One clock of the script: expected state, ready value, whether the edge retires.
    task automatic cyc(input logic [3:0] st, input logic r, input bit ret);
        exp_state = st;
        rdy = r;
        icyc++;
        @(negedge clk);
        if (st == S_EXECR || st == S_EXECI) alu_seen = a_alu;
        if (st == S_BEQ) pcw_seen = a_pcw;
        @(posedge clk);
        #1;
        if (ret) exp_count++;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f, input logic f7b,
                         input logic z, input int fs, input int ms);
        bit f3_ok;
        op = o; f3 = f; f7 = f7b; zero = z; icyc = 0;
        f3_ok = (f == 3'b000) || (f == 3'b010) || (f == 3'b110) || (f == 3'b111);
        repeat (fs) cyc(S_FETCH, 1'b0, 1'b0);
        cyc(S_FETCH, 1'b1, 1'b0);
        cyc(S_DECODE, rnd(), 1'b0);
        if (o == LW) begin
            cyc(S_MEMADR, rnd(), 1'b0);
            repeat (ms) cyc(S_MEMREAD, 1'b0, 1'b0);
            cyc(S_MEMREAD, 1'b1, 1'b0);
            cyc(S_MEMWB, rnd(), 1'b1);
        end else if (o == SW) begin
            cyc(S_MEMADR, rnd(), 1'b0);
            repeat (ms) cyc(S_MEMWRITE, 1'b0, 1'b0);
            cyc(S_MEMWRITE, 1'b1, 1'b1);
        end else if ((o == RT || o == IT) && f3_ok) begin
            cyc((o == RT) ? S_EXECR : S_EXECI, rnd(), 1'b0);
            cyc(S_ALUWB, rnd(), 1'b1);
        end else if (o == BR && f == 3'b000) begin
            cyc(S_BEQ, rnd(), 1'b1);
        end else if (o == JL) begin
            cyc(S_JAL, rnd(), 1'b0);
            cyc(S_ALUWB, rnd(), 1'b1);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; chk_en = 1'b0; rdy = 1'b0;
        #1;
        check("rst_state", 32'(a_state), 32'(S_FETCH));
        check("rst_halted", 32'(a_halt), 32'd0);
        check("rst_instret", a_instret, 32'd0);
        check("rst_instret_w4", 32'(b_instret), 32'd0);
        check("rst_mem_req", 32'(a_req), 32'd1);
        check("rst_ir_write", 32'(a_irw), 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1; exp_count = 0; exp_state = S_FETCH; chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0; rdy = 1'b0;
        #2;
        do_reset();

        instr(LW, 3'b010, 1'b0, 1'b0, 0, 0);
        check("lw_cycles", 32'(icyc), 32'd5);
        check("lw_instret", a_instret, 32'd1);

        instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
        check("add_alu", 32'(alu_seen), 32'd0);
        check("add_cycles", 32'(icyc), 32'd4);
        instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        check("sub_alu", 32'(alu_seen), 32'd1);
        check("sub_instret", a_instret, 32'd3);
        instr(RT, 3'b010, 1'b0, 1'b0, 0, 0);
        check("slt_alu", 32'(alu_seen), 32'd5);
        instr(RT, 3'b110, 1'b0, 1'b0, 0, 0);
        check("or_alu", 32'(alu_seen), 32'd3);
        instr(RT, 3'b111, 1'b0, 1'b0, 0, 0);
        check("and_alu", 32'(alu_seen), 32'd2);
        instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
        check("addi_alu", 32'(alu_seen), 32'd0);
        instr(IT, 3'b010, 1'b0, 1'b0, 0, 0);
        instr(IT, 3'b111, 1'b0, 1'b0, 0, 0);
        check("itype_instret", a_instret, 32'd9);

        instr(BR, 3'b000, 1'b0, 1'b1, 0, 0);
        check("beq_taken_pcw", 32'(pcw_seen), 32'd1);
        check("beq_cycles", 32'(icyc), 32'd3);
        instr(BR, 3'b000, 1'b0, 1'b0, 0, 0);
        check("beq_not_taken_pcw", 32'(pcw_seen), 32'd0);
        instr(JL, 3'b000, 1'b0, 1'b0, 0, 0);
        check("jal_cycles", 32'(icyc), 32'd4);

        instr(RT, 3'b000, 1'b0, 1'b0, 3, 0);
        check("fetch_stall_cycles", 32'(icyc), 32'd7);
        instr(SW, 3'b010, 1'b0, 1'b0, 2, 2);
        check("sw_stall_cycles", 32'(icyc), 32'd8);
        instr(LW, 3'b010, 1'b0, 1'b0, 0, 1);
        check("lw_stall_cycles", 32'(icyc), 32'd6);
        check("mix_instret", a_instret, 32'd15);
        check("mix_instret_w4", 32'(b_instret), 32'd15);

        instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
        repeat (20) cyc(S_HALT, rnd(), 1'b0);
        check("halt_flag", 32'(a_halt), 32'd1);
        check("halt_instret", a_instret, 32'd15);
        do_reset();

        instr(RT, 3'b001, 1'b0, 1'b0, 0, 0);
        repeat (3) cyc(S_HALT, rnd(), 1'b0);
        do_reset();
        instr(BR, 3'b001, 1'b0, 1'b1, 0, 0);
        repeat (3) cyc(S_HALT, rnd(), 1'b0);
        do_reset();

        for (int i = 0; i < 17; i++) instr(IT, 3'b110, 1'b0, 1'b0, 0, 0);
        check("wrap_instret_w4", 32'(b_instret), 32'd1);
        check("wrap_instret", a_instret, 32'd17);

        // Reset lands in the middle of a stalled load read.
        op = LW; f3 = 3'b010; f7 = 1'b0; zero = 1'b0;
        cyc(S_FETCH, 1'b1, 1'b0);
        cyc(S_DECODE, rnd(), 1'b0);
        cyc(S_MEMADR, rnd(), 1'b0);
        rw_cnt = 0; rw_mon = 1'b1;
        cyc(S_MEMREAD, 1'b0, 1'b0);
        exp_state = S_MEMREAD; rdy = 1'b0;
        #2;
        do_reset();
        repeat (2) cyc(S_FETCH, 1'b0, 1'b0);
        rw_mon = 1'b0;
        check("abort_reg_write", 32'(rw_cnt), 32'd0);
        check("abort_instret", a_instret, 32'd0);
        instr(IT, 3'b000, 1'b0, 1'b0, 0, 0);
        check("after_abort_instret", a_instret, 32'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
